// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge and related bus bridges.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/grant/rvalid data-memory bus; master is the bridge, slave is the RAM or fabric.
interface dmem_bridge_if;
  import dmem_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [BE_W-1:0]   bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

endinterface

// File: rtl/dmem_bridge_rd_align.sv
// Right-aligns a read word by a byte offset so sub-word loads land on bit 0.
module rd_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] aligned
);

  assign aligned = data >> {offset, 3'b000};

endmodule

// File: rtl/dmem_bridge.sv
// Runs the memory-stage load/store on the req/gnt/rvalid bus and stalls the
// pipeline until the access completes, errors or times out.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [BE_W-1:0]   dmem_wr,
  input  logic [DATA_W-1:0] datamem_wr_o,
  input  logic              ld_req,
  output logic              stall_o,
  output logic [DATA_W-1:0] datamem_rd_in,
  output logic              dmem_err,
  dmem_bridge_if.master     bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        byte_off;
  logic [DATA_W-1:0] rd_aligned;

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  logic is_store;
  logic access;
  logic timed_out;
  logic rd_capture;
  logic abort;
  logic fin_err;

  assign is_store  = |dmem_wr;
  assign access    = is_store | ld_req;
  assign timed_out = (cnt >= CNT_LAST);

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  assign stall_o = rstn & (((state == IDLE) & access) | (state == REQ) | (state == WAIT_R));

  rd_align u_rd_align (
    .data    (bus.bus_rdata),
    .offset  (byte_off),
    .aligned (rd_aligned)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // A completion seen in the same cycle as the timeout limit wins over the abort.
  always_comb begin
    next_state = state;
    rd_capture = 1'b0;
    abort      = 1'b0;
    fin_err    = 1'b0;
    case (state)
      IDLE: begin
        if (access) next_state = REQ;
      end
      REQ: begin
        if (bus.bus_gnt) begin
          if (we_q) begin
            next_state = DONE;
            fin_err    = bus.bus_err;
          end else begin
            next_state = WAIT_R;
          end
        end else if (timed_out) begin
          next_state = DONE;
          abort      = 1'b1;
          fin_err    = 1'b1;
        end
      end
      WAIT_R: begin
        if (bus.bus_rvalid) begin
          next_state = DONE;
          rd_capture = 1'b1;
          fin_err    = bus.bus_err;
        end else if (timed_out) begin
          next_state = DONE;
          abort      = 1'b1;
          fin_err    = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      byte_off      <= 2'b00;
      cnt           <= '0;
      datamem_rd_in <= '0;
      dmem_err      <= 1'b0;
    end else begin
      dmem_err <= fin_err;
      if ((state == IDLE) && access) begin
        req_q    <= 1'b1;
        we_q     <= is_store;
        addr_q   <= {data_addr[ADDR_W-1:2], 2'b00};
        be_q     <= is_store ? dmem_wr : BE_WORD;
        wdata_q  <= datamem_wr_o;
        byte_off <= data_addr[1:0];
        cnt      <= '0;
      end else if ((state == REQ) || (state == WAIT_R)) begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == REQ) && (bus.bus_gnt || abort)) req_q <= 1'b0;
      // Alignment uses the offset latched at request time, not the live address.
      if (rd_capture)  datamem_rd_in <= bus.bus_err ? '0 : rd_aligned;
      else if (abort)  datamem_rd_in <= '0;
    end
  end

endmodule
